// File: rtl/arb_req_client_if.sv
// arb_req_client_if
//   Bundle of the command channel and arbiter-side signals of one
//   arb_req_client instance.
//   slave  : the requester agent (consumes commands and gnt, drives the rest)
//   master : the environment (local master plus arbiter) facing the agent
//   Signals:
//     cmd_valid/cmd_len/cmd_ready : burst command handshake (len = beats-1)
//     req/gnt                     : arbiter request / grant
//     beat/busy/done/timeout_err  : status
interface arb_req_client_if #(
  parameter int LEN_W = 4
) ();
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             gnt;
  logic             beat;
  logic             busy;
  logic             done;
  logic             timeout_err;

  modport master (
    output cmd_valid, cmd_len, gnt,
    input  cmd_ready, req, beat, busy, done, timeout_err
  );

  modport slave (
    input  cmd_valid, cmd_len, gnt,
    output cmd_ready, req, beat, busy, done, timeout_err
  );
endinterface

// File: rtl/arb_req_client.sv
// arb_req_client
//   Requester-side agent for the two-way grant arbiter. Queues burst
//   commands in a small FIFO, raises req for the head command, holds it for
//   exactly cmd_len+1 granted beats, then drops req for one REL cycle.
//   Ports:
//     clock    : rising-edge clock
//     reset_n  : asynchronous active-low reset
//     bus      : arb_req_client_if.slave (command channel, req/gnt, status)
//   Optional feature (macro ARB_REQ_TIMEOUT_EN): a request that sees no
//   grant for TIMEOUT cycles in REQ is abandoned and timeout_err pulses.
//   Without the macro REQ waits indefinitely and timeout_err is 0.
module arb_req_client #(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int TIMEOUT    = 15   // >= 1
) (
  input logic            clock,
  input logic            reset_n,
  arb_req_client_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_REL} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic             req_q;
  logic             done_q;

  // command FIFO
  logic [LEN_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, fifo_ne;

  assign fifo_ne       = (count != '0);
  assign bus.cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push          = bus.cmd_valid & bus.cmd_ready;
  // the only pop is the IDLE->REQ transition
  assign pop           = (state == S_IDLE) & fifo_ne;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.cmd_len;
  end

  // depth is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wcnt;
  logic            toe_q;
  assign bus.timeout_err = toe_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // req is written alongside the state so it reflects the state being
  // entered: high for REQ/OWN, low for IDLE/REL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      rem    <= '0;
      req_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      wcnt   <= '0;
      toe_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      toe_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (fifo_ne) begin
            state <= S_REQ;
            req_q <= 1'b1;
            rem   <= mem[rd_ptr];
`ifdef ARB_REQ_TIMEOUT_EN
            wcnt  <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus.gnt) begin
            if (rem == '0) begin
              state  <= S_REL;
              req_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              rem   <= rem - LEN_W'(1);
              state <= S_OWN;
            end
          end
`ifdef ARB_REQ_TIMEOUT_EN
          // this is the TIMEOUT-th ungranted REQ cycle; a grant in the same
          // cycle takes the branch above instead
          else if (wcnt == TO_W'(TIMEOUT - 1)) begin
            state <= S_REL;
            req_q <= 1'b0;
            toe_q <= 1'b1;
          end else begin
            wcnt <= wcnt + TO_W'(1);
          end
`endif
        end
        S_OWN: begin
          // preemption (gnt=0) simply holds everything; req stays up
          if (bus.gnt) begin
            if (rem == '0) begin
              state  <= S_REL;
              req_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              rem <= rem - LEN_W'(1);
            end
          end
        end
        S_REL: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req  = req_q;
  assign bus.done = done_q;
  assign bus.beat = bus.gnt & ((state == S_REQ) | (state == S_OWN));
  assign bus.busy = (state != S_IDLE) | fifo_ne;
endmodule
